// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_sequencer_pkg
// Shared definitions for the pong staged reset controller and the other pong
// clock-domain blocks that reuse the power-on hold length.
//   state_t             : sequencer FSM encoding (HOLD, WAIT_ACK, GAP, RUN)
//   STATE_W / STAGE_W   : widths of the state register and of the stage index
//   DEFAULT_HOLD_CYCLES : power-on hold length used across the pong design
// -----------------------------------------------------------------------------
package reset_sequencer_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned STAGE_W = 3;

    localparam int unsigned DEFAULT_HOLD_CYCLES = 32'h000F_FFFF;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_GAP      = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

endpackage : reset_sequencer_pkg

// File: rtl/reset_sync.sv
// -----------------------------------------------------------------------------
// reset_sync
// Two-flop reset synchronizer: asserts asynchronously with async_rst_in and
// releases synchronously, two clk edges after async_rst_in falls.
// Ports:
//   clk          in  : destination clock
//   async_rst_in in  : active-high asynchronous reset request
//   sync_rst_out out : active-high reset, deassertion aligned to clk
// -----------------------------------------------------------------------------
module reset_sync (
    input  logic clk,
    input  logic async_rst_in,
    output logic sync_rst_out
);

    logic [1:0] sync_r;

    // Shift zeros in once the asynchronous request is gone.
    always_ff @(posedge clk or posedge async_rst_in) begin
        if (async_rst_in) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], 1'b0};
        end
    end

    assign sync_rst_out = sync_r[1];

endmodule : reset_sync

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Staged reset controller for the pong design. Stretches the board reset
// button into a long hold, then releases NUM_STAGES reset domains one by one
// (bit 0 first), waiting for each domain's ready ack (bounded by a timeout)
// plus an idle gap before releasing the next. A soft reset request from the
// game logic re-runs the whole sequence.
// Ports:
//   clk          in  : system clock
//   rst_button   in  : board reset, asynchronous, active-high
//   soft_rst_req in  : synchronous active-high request to restart the sequence
//   stage_ack    in  : per-domain ready acknowledge
//   rst_out      out : per-domain active-high reset
//   sys_ready    out : all domains released and acknowledged
//   cur_stage    out : index of the stage being released/awaited
//   timeout_err  out : sticky flag, some stage ack timed out
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned CNT_W       = 20
) (
    input  logic                  clk,
    input  logic                  rst_button,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  sys_ready,
    output logic [STAGE_W-1:0]    cur_stage,
    output logic                  timeout_err
);

    // Terminal counts: every wait ends on an exact match, so the counter
    // never has to wrap.
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(STAGE_GAP - 32'd1);
    localparam logic [CNT_W-1:0]   ACK_LAST   = CNT_W'(ACK_TIMEOUT - 32'd1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 32'd1);

    logic                  int_rst_s;
    logic                  ack_sel_s;
    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [NUM_STAGES-1:0] rst_out_r;
    logic                  sys_ready_r;
    logic [STAGE_W-1:0]    cur_stage_r;
    logic                  timeout_err_r;

    reset_sync u_reset_sync (
        .clk          (clk),
        .async_rst_in (rst_button),
        .sync_rst_out (int_rst_s)
    );

    // Pick the ack of the stage currently awaited; other bits are ignored.
    always_comb begin
        ack_sel_s = 1'b0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            ack_sel_s = ack_sel_s | (stage_ack[i] & (cur_stage_r == STAGE_W'(i)));
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge int_rst_s) begin
        if (int_rst_s) begin
            state_r       <= ST_HOLD;
            cnt_r         <= {CNT_W{1'b0}};
            rst_out_r     <= {NUM_STAGES{1'b1}};
            sys_ready_r   <= 1'b0;
            cur_stage_r   <= {STAGE_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else if (soft_rst_req) begin
            // Restart the full sequence; the timeout history is kept so the
            // game logic can still report it after its own restart.
            state_r     <= ST_HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            rst_out_r   <= {NUM_STAGES{1'b1}};
            sys_ready_r <= 1'b0;
            cur_stage_r <= {STAGE_W{1'b0}};
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        // Bits release strictly in order, so a left shift
                        // clears exactly the next stage's reset.
                        rst_out_r <= rst_out_r << 1;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= ST_WAIT_ACK;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_sel_s || (cnt_r == ACK_LAST)) begin
                        timeout_err_r <= timeout_err_r | ~ack_sel_s;
                        cnt_r         <= {CNT_W{1'b0}};
                        if (cur_stage_r == LAST_STAGE) begin
                            sys_ready_r <= 1'b1;
                            state_r     <= ST_RUN;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        cur_stage_r <= cur_stage_r + STAGE_W'(1);
                        rst_out_r   <= rst_out_r << 1;
                        cnt_r       <= {CNT_W{1'b0}};
                        state_r     <= ST_WAIT_ACK;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // Domains stay released; later ack drops are ignored.
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r     <= ST_HOLD;
                    cnt_r       <= {CNT_W{1'b0}};
                    rst_out_r   <= {NUM_STAGES{1'b1}};
                    sys_ready_r <= 1'b0;
                    cur_stage_r <= {STAGE_W{1'b0}};
                end
            endcase
        end
    end

    assign rst_out     = rst_out_r;
    assign sys_ready   = sys_ready_r;
    assign cur_stage   = cur_stage_r;
    assign timeout_err = timeout_err_r;

endmodule : reset_sequencer
